sum_accum_seq: RTL and testbench

- Downstream stage of the 4-bit signed adder. It consumes that adder's 5-bit `sum` results one at a time through a valid/ready handshake.
- It accumulates a frame of N results into a wider signed running total.
- It presents the frame total through a valid/ready output handshake.
- It tracks signed overflow of the accumulator.

---
 rtl/adder_pkg.sv | 6 +
 rtl/sat_add.sv | 21 ++
 rtl/sum_accum_seq.sv | 42 ++++
 tb/tb_sum_accum_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and FSM state encoding for the sum accumulator
package adder_pkg;
  localparam int SUM_W = 5;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sat_add.sv
// sat_add: signed accumulator adder with overflow detect; saturates when SUM_ACCUM_SAT_EN is defined, else wraps
module sat_add
  import adder_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic [ACC_W-1:0] y,
  output logic             ovf
);
  logic [ACC_W-1:0] b_ext, raw;
  assign b_ext = {{(ACC_W-SUM_W){b[SUM_W-1]}}, b};
  assign raw = a + b_ext;
  assign ovf = (a[ACC_W-1] == b_ext[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef SUM_ACCUM_SAT_EN
  assign y = !ovf ? raw : a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign y = raw;
`endif
endmodule

// File: rtl/sum_accum_seq.sv
// sum_accum_seq: accumulates N_SAMPLES adder sums per frame behind valid/ready handshakes (SUM_ACCUM_SAT_EN selects saturation)
module sum_accum_seq
  import adder_pkg::*;
#(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             ovf
);
  state_t           state;
  logic [ACC_W-1:0] add_y;
  logic             add_ovf;
  logic             accept;
  sat_add #(.ACC_W(ACC_W)) u_add (.a(acc_out), .b(sum_in), .y(add_y), .ovf(add_ovf));
  assign in_ready = rst_n & ~clear & (state != DONE);
  assign accept = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n || clear || (out_valid && out_ready)) begin
      state      <= IDLE;
      acc_out    <= '0;
      sample_cnt <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      acc_out    <= add_y;
      sample_cnt <= sample_cnt + 1'b1;
      ovf        <= ovf | add_ovf;
      state      <= (sample_cnt == CNT_W'(N_SAMPLES - 1)) ? DONE : ACCUM;
      out_valid  <= (sample_cnt == CNT_W'(N_SAMPLES - 1));
    end
  end
endmodule

// File: tb/tb_sum_accum_seq.sv
// tb_sum_accum_seq: directed self-checking bench over three configurations (N4/W8, N4/W6, N1/W8)
module tb_sum_accum_seq;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [4:0] sum_in = '0;
  logic iready[3], ovalid[3], ovf[3];
  logic [7:0] cnt[3];
  logic [7:0] acc_a, acc_c;
  logic [5:0] acc_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sum_accum_seq #(.N_SAMPLES(4), .ACC_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(iready[0]), .sum_in(sum_in), .out_valid(ovalid[0]),
    .out_ready(out_ready), .acc_out(acc_a), .sample_cnt(cnt[0]), .ovf(ovf[0]));
  sum_accum_seq #(.N_SAMPLES(4), .ACC_W(6)) dut_b (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(iready[1]), .sum_in(sum_in), .out_valid(ovalid[1]),
    .out_ready(out_ready), .acc_out(acc_b), .sample_cnt(cnt[1]), .ovf(ovf[1]));
  sum_accum_seq #(.N_SAMPLES(1), .ACC_W(8)) dut_c (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(iready[2]), .sum_in(sum_in), .out_valid(ovalid[2]),
    .out_ready(out_ready), .acc_out(acc_c), .sample_cnt(cnt[2]), .ovf(ovf[2]));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    in_valid = 1;
    sum_in = 5'(v);
    @(negedge clk);
  endtask

  task automatic idle_a(input string tag);
    chk({tag, " ovalid"}, ovalid[0], 0);
    chk({tag, " acc"}, $signed(acc_a), 0);
    chk({tag, " cnt"}, cnt[0], 0);
    chk({tag, " ovf"}, ovf[0], 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst in_ready", iready[0], 0);
    idle_a("rst");
    rst_n = 1;
    #1 chk("post-rst in_ready", iready[0], 1);
    // basic frame
    out_ready = 1;
    send(3); send(5); send(-2);
    chk("basic pre ovalid", ovalid[0], 0);
    chk("basic pre cnt", cnt[0], 3);
    send(7);
    in_valid = 0;
    chk("basic ovalid", ovalid[0], 1);
    chk("basic acc", $signed(acc_a), 13);
    chk("basic cnt", cnt[0], 4);
    chk("basic ovf", ovf[0], 0);
    chk("basic done in_ready", iready[0], 0);
    @(negedge clk);
    idle_a("basic after");
    // backpressure
    out_ready = 0;
    send(1); send(1); send(1); send(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp in_ready", iready[0], 0);
      chk("bp ovalid", ovalid[0], 1);
      chk("bp acc", $signed(acc_a), 4);
      chk("bp cnt", cnt[0], 4);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    idle_a("bp xfer");
    chk("bp idle in_ready", iready[0], 1);
    @(negedge clk);
    chk("bp next cnt", cnt[0], 1);
    chk("bp next acc", $signed(acc_a), 1);
    in_valid = 0;
    out_ready = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    idle_a("clr1");
    // overflow on the 6-bit instance
    send(15); send(15);
    chk("ovf2 flag", ovf[1], 0);
    chk("ovf2 acc", $signed(acc_b), 30);
    send(15);
    chk("ovf3 flag", ovf[1], 1);
`ifdef SUM_ACCUM_SAT_EN
    chk("ovf3 acc", $signed(acc_b), 31);
`else
    chk("ovf3 acc", $signed(acc_b), -19);
`endif
    send(15);
    in_valid = 0;
    chk("ovf4 ovalid", ovalid[1], 1);
    chk("ovf4 flag", ovf[1], 1);
`ifdef SUM_ACCUM_SAT_EN
    chk("ovf4 acc", $signed(acc_b), 31);
`else
    chk("ovf4 acc", $signed(acc_b), -4);
`endif
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clr ovf", ovf[1], 0);
    // negative extreme
    send(-16); send(-16); send(-16); send(-16);
    in_valid = 0;
    chk("neg ovalid", ovalid[0], 1);
    chk("neg acc raw", {24'd0, acc_a}, 32'hC0);
    chk("neg ovf", ovf[0], 0);
    clear = 1;
    @(negedge clk);
    clear = 0;
    // mid-frame clear with a competing sample
    send(2); send(4);
    chk("mid acc", $signed(acc_a), 6);
    clear = 1;
    sum_in = 5'd9;
    #1 chk("mid clr in_ready", iready[0], 0);
    @(negedge clk);
    clear = 0;
    in_valid = 0;
    idle_a("mid clr");
    out_ready = 1;
    send(1); send(1); send(1); send(1);
    in_valid = 0;
    chk("mid next ovalid", ovalid[0], 1);
    chk("mid next acc", $signed(acc_a), 4);
    out_ready = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    // N=1 corner with reset while holding a result
    send(3);
    in_valid = 0;
    chk("n1 ovalid", ovalid[2], 1);
    chk("n1 acc", $signed(acc_c), 3);
    chk("n1 cnt", cnt[2], 1);
    rst_n = 0;
    @(negedge clk);
    chk("n1 rst ovalid", ovalid[2], 0);
    chk("n1 rst acc", $signed(acc_c), 0);
    chk("n1 rst in_ready", iready[2], 0);
    rst_n = 1;
    send(-7);
    in_valid = 0;
    chk("n1 -7 ovalid", ovalid[2], 1);
    chk("n1 -7 acc", $signed(acc_c), -7);
    out_ready = 1;
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("n1 clear beats xfer", ovalid[2], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
